mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one single-port synchronous memory between the instruction-fetch path and the load/store path of the CPU.
- Each cycle it picks one requester, drives the memory port, and tracks read ownership through a fixed-latency pipeline so each read response returns to the requester that issued it.
- Sits in the processor top level between the PC/fetch logic, the CPU load/store unit and the memory instance.

Parameters:
- AW, 32, address width in bits (byte address).
- DW, 32, data width in bits.
- MEM_LAT, 1, cycles from an accepted read (m_en=1, m_we=0 at a posedge) to valid m_rdata. Legal range 1..4.
- STARVE_MAX, 4, number of consecutive data grants allowed while a fetch is pending. Legal range 1..15.

Ports:
- CLK  input  1  clock, rising edge.
- RST_X  input  1  asynchronous active-low reset.
- i_req  input  1  fetch request.
- i_addr  input  AW  fetch address.
- i_gnt  output  1  fetch accepted this cycle.
- i_rvalid  output  1  fetch data valid.
- i_rdata  output  DW  fetch data.
- d_req  input  1  data request.
- d_we  input  1  1 = write, 0 = read.
- d_addr  input  AW  data address.
- d_wdata  input  DW  write data.
- d_wstrb  input  DW/8  byte write enables.
- d_gnt  output  1  data request accepted this cycle.
- d_rvalid  output  1  data read response valid.
- d_rdata  output  DW  data read response.
- m_en  output  1  memory access enable.
- m_we  output  1  memory write enable.
- m_addr  output  AW  memory address.
- m_wdata  output  DW  memory write data.
- m_wstrb  output  DW/8  memory byte enables.
- m_rdata  input  DW  memory read data.

Behaviour:
- Handshake: a request is accepted in the cycle where req && gnt are sampled at a posedge.
  - The requester holds req, addr, we, wdata and wstrb stable until gnt.
  - gnt is combinational from the req inputs and registered state, in the same cycle. There are no bubbles, so back-to-back acceptances are allowed every cycle.
- Arbitration (combinational):
  - Only d_req: data wins.
  - Only i_req: fetch wins.
  - Both: data wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
  - Exactly one gnt is high whenever any req is high.
- Memory drive:
  - m_en = i_req | d_req.
  - m_addr, m_we, m_wdata and m_wstrb come from the winner.
  - A fetch winner forces m_we=0 and m_wstrb=0.
  - With no request: m_en=0, m_we=0, all other memory outputs 0.
- starve_cnt (4-bit register):
  - Increments on a data grant while i_req=1, saturating at STARVE_MAX.
  - Clears on a fetch grant or in any cycle with i_req=0.
- Ownership pipeline: MEM_LAT-deep shift register of {valid, owner}.
  - Stage 0 is loaded with valid=1 for an accepted read; owner=0 for fetch, 1 for data.
  - Writes load valid=0. Writes produce no response.
  - The pipeline shifts every cycle.
- Response routing (combinational from the last stage):
  - i_rvalid = last.valid && owner==0.
  - d_rvalid = last.valid && owner==1.
  - i_rdata = d_rdata = m_rdata, always; consumers qualify with rvalid.
  - Responses cannot be stalled.
  - Response order per requester equals acceptance order.
- Simultaneous events: a response and a new acceptance in the same cycle are independent.
- Reset (RST_X=0, asynchronous):
  - Pipeline valids and starve_cnt clear to 0.
  - i_rvalid=0, d_rvalid=0.
  - gnt and m_* follow the req inputs combinationally; requesters must hold req low during reset.
  - Reads in flight at reset assertion are dropped. No response appears after reset release for a pre-reset access.
- Simulation check: the bench flags any cycle where both gnt are high.

Decomposition:
- Shared package `mem_pkg`:
  - Owner encoding constants OWN_I=0 and OWN_D=1.
  - Default widths AW/DW.
  - Request struct fields {we, addr, wdata, wstrb}.
- Natural sub-module: `owner_pipe`, the parameterised MEM_LAT-deep valid/owner shift register with asynchronous clear.
- Arbitration and starvation counter stay in mem_arbiter.

Test Plan:
- Fetch only, MEM_LAT=1:
  - Stimulus: i_req=1, i_addr 0, 4, 8 on consecutive cycles; memory returns the address as data.
  - Required: i_gnt=1 each cycle; i_rvalid one cycle after each acceptance with i_rdata 0, 4, 8; d_rvalid never high.
- Contention, STARVE_MAX=4:
  - Stimulus: i_req and d_req held high for 10 cycles.
  - Required grant sequence: D,D,D,D,I,D,D,D,D,I.
- Mixed read/write:
  - Stimulus: d write addr 0x10 data 0xDEADBEEF wstrb 0xF, then d read addr 0x10.
  - Required: write drives m_we=1 and produces no d_rvalid; the read gives d_rvalid with d_rdata=0xDEADBEEF one cycle later.
- MEM_LAT=3, interleaved reads:
  - Stimulus: reads accepted in order I(0x0), D(0x20), I(0x4).
  - Required: i_rvalid, d_rvalid, i_rvalid on cycles +3, +4, +5 with matching data.
- Reset mid-flight, MEM_LAT=3:
  - Stimulus: two reads accepted, RST_X pulsed low for 1 cycle.
  - Required: no rvalid after release; starve_cnt=0; the next contention cycle grants data.
- Idle:
  - Stimulus: no requests.
  - Required: m_en=0, m_we=0, both gnt=0, no rvalid.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared widths, owner encoding and request payload for the memory arbiter.
package mem_pkg;

   localparam int unsigned DEF_AW = 32;
   localparam int unsigned DEF_DW = 32;
   localparam int unsigned DEF_SW = DEF_DW / 8;

   // Owner tag carried through the read-ownership pipeline
   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   // Winning request as presented to the memory port
   typedef struct packed {
      logic              we;
      logic [DEF_AW-1:0] addr;
      logic [DEF_DW-1:0] wdata;
      logic [DEF_SW-1:0] wstrb;
   } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, load/store and memory-port signals shared by the arbiter and its neighbours.
interface mem_arbiter_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);
   localparam int unsigned SW = DW / 8;

   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_gnt;
   logic          i_rvalid;
   logic [DW-1:0] i_rdata;

   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [SW-1:0] d_wstrb;
   logic          d_gnt;
   logic          d_rvalid;
   logic [DW-1:0] d_rdata;

   logic          m_en;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [SW-1:0] m_wstrb;
   logic [DW-1:0] m_rdata;

   // Arbiter side
   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, m_rdata,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
      output m_en, m_we, m_addr, m_wdata, m_wstrb
   );

   // Requesters and memory side
   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, m_rdata,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
      input  m_en, m_we, m_addr, m_wdata, m_wstrb
   );

endinterface

// File: rtl/owner_pipe.sv
// DEPTH-stage {valid, owner} shift register tracking which requester owns each read in flight.
module owner_pipe #(
   parameter int unsigned DEPTH = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_valid,
   input  logic in_owner,
   output logic out_valid,
   output logic out_owner
);

   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] owner_q;

   // Shift every cycle; asynchronous clear drops reads in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         owner_q <= '0;
      end else begin
         valid_q[0] <= in_valid;
         owner_q[0] <= in_owner;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
            owner_q[i] <= owner_q[i-1];
         end
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_owner = owner_q[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch and load/store, routing read data back to its owner.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int unsigned AW         = DEF_AW,
   parameter int unsigned DW         = DEF_DW,
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input logic          CLK,
   input logic          RST_X,
   mem_arbiter_if.slave bus
);

   localparam int unsigned SW   = DW / 8;
   localparam int unsigned CW   = 4;
   localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

   logic [CW-1:0] starve_cnt;
   logic [CW-1:0] starve_nxt;
   logic          gnt_i;
   logic          gnt_d;
   mem_req_t      win;
   logic          pipe_in_valid;
   logic          pipe_in_owner;
   logic          pipe_valid;
   logic          pipe_owner;

   // Data has priority unless fetch has already lost STARVE_MAX times in a row
   always_comb begin
      gnt_i = bus.i_req & (~bus.d_req | (starve_cnt == SMAX));
      gnt_d = bus.d_req & ~gnt_i;
   end

   assign bus.i_gnt = gnt_i;
   assign bus.d_gnt = gnt_d;

   // Select the winning request; fetch never writes
   always_comb begin
      win = '0;
      if (gnt_i) begin
         win.addr = DEF_AW'(bus.i_addr);
      end else if (gnt_d) begin
         win.we    = bus.d_we;
         win.addr  = DEF_AW'(bus.d_addr);
         win.wdata = DEF_DW'(bus.d_wdata);
         win.wstrb = DEF_SW'(bus.d_wstrb);
      end
   end

   assign bus.m_en    = bus.i_req | bus.d_req;
   assign bus.m_we    = win.we;
   assign bus.m_addr  = AW'(win.addr);
   assign bus.m_wdata = DW'(win.wdata);
   assign bus.m_wstrb = SW'(win.wstrb);

   // Starvation counter: counts data wins over a waiting fetch, saturating
   always_comb begin
      starve_nxt = starve_cnt;
      if (!bus.i_req || gnt_i) begin
         starve_nxt = '0;
      end else if (gnt_d && (starve_cnt != SMAX)) begin
         starve_nxt = starve_cnt + 1'b1;
      end
   end

   // Starvation counter register
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         starve_cnt <= '0;
      end else begin
         starve_cnt <= starve_nxt;
      end
   end

   // Tag accepted reads with their owner; writes enter as bubbles
   always_comb begin
      pipe_in_valid = gnt_i | (gnt_d & ~bus.d_we);
      pipe_in_owner = gnt_d ? OWN_D : OWN_I;
   end

   owner_pipe #(
      .DEPTH (MEM_LAT)
   ) u_owner_pipe (
      .clk       (CLK),
      .rst_n     (RST_X),
      .in_valid  (pipe_in_valid),
      .in_owner  (pipe_in_owner),
      .out_valid (pipe_valid),
      .out_owner (pipe_owner)
   );

   assign bus.i_rvalid = pipe_valid & (pipe_owner == OWN_I);
   assign bus.d_rvalid = pipe_valid & (pipe_owner == OWN_D);
   assign bus.i_rdata  = bus.m_rdata;
   assign bus.d_rdata  = bus.m_rdata;

endmodule
